// File: rtl/mul_ctrl.sv
// Purpose: register-bus front end for the 32x32 signed multiplier. It holds the
//          operands, runs the op_start/op_clear handshake and captures the product.
// Latency: a start write in cycle N raises op_start in N+1. op_done in cycle M makes
//          the product, done and the interrupt visible in M+1, with op_clear pulsing in M+1.
// Backpressure: none. Operand and start writes while busy are dropped and flag ovr.
//
// Ports:
//   clk, reset_n            clock and asynchronous active-low reset (shared with mul)
//   s_sel/s_wr/s_addr/s_din single-cycle register bus; s_dout is combinational read data
//   m_interrupt             level interrupt = INTEN & (done | err)
//   op_start/op_clear       handshake to mul; multiplicand/multiplier mirror OPA/OPB
//   op_done/result          completion strobe and 64-bit product from mul
module mul_ctrl #(
  parameter int TIMEOUT = 127
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s_sel,
  input  logic        s_wr,
  input  logic [2:0]  s_addr,
  input  logic [31:0] s_din,
  output logic [31:0] s_dout,
  output logic        m_interrupt,
  output logic        op_start,
  output logic        op_clear,
  output logic [31:0] multiplicand,
  output logic [31:0] multiplier,
  input  logic        op_done,
  input  logic [63:0] result
);

  localparam logic [2:0] A_OPA    = 3'd0;
  localparam logic [2:0] A_OPB    = 3'd1;
  localparam logic [2:0] A_CTRL   = 3'd2;
  localparam logic [2:0] A_INTEN  = 3'd3;
  localparam logic [2:0] A_STATUS = 3'd4;
  localparam logic [2:0] A_RES_L  = 3'd5;
  localparam logic [2:0] A_RES_H  = 3'd6;

  // Last EXEC cycle index before giving up on op_done.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] res_l_q, res_l_d;
  logic [31:0] res_h_q, res_h_d;
  logic        inten_q, inten_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        ovr_q, ovr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        start_q, start_d;
  logic        clear_q, clear_d;
  logic        irq_q, irq_d;

  logic wr, wr_opa, wr_opb, wr_ctrl, wr_inten, wr_status;
  logic busy;

  assign wr        = s_sel & s_wr;
  assign wr_opa    = wr & (s_addr == A_OPA);
  assign wr_opb    = wr & (s_addr == A_OPB);
  assign wr_ctrl   = wr & (s_addr == A_CTRL);
  assign wr_inten  = wr & (s_addr == A_INTEN);
  assign wr_status = wr & (s_addr == A_STATUS);
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_l_d = res_l_q;
    res_h_d = res_h_q;
    inten_d = inten_q;
    done_d  = done_q;
    err_d   = err_q;
    ovr_d   = ovr_q;
    cnt_d   = cnt_q;
    start_d = start_q;
    clear_d = clear_q;

    if (wr_inten) begin
      inten_d = s_din[0];
    end

    // Status clears are applied first so that any same-cycle set below overrides them.
    if (wr_status) begin
      if (s_din[1]) done_d = 1'b0;
      if (s_din[2]) err_d  = 1'b0;
      if (s_din[3]) ovr_d  = 1'b0;
    end

    if (busy && (wr_opa || wr_opb || (wr_ctrl && s_din[0]))) begin
      ovr_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (wr_opa) opa_d = s_din;
        if (wr_opb) opb_d = s_din;
        if (wr_ctrl && s_din[1]) begin
          // Clear beats start when both bits are written together.
          state_d = CLEAR;
          clear_d = 1'b1;
        end else if (wr_ctrl && s_din[0]) begin
          state_d = EXEC;
          start_d = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          cnt_d   = 8'd0;
        end
      end
      EXEC: begin
        cnt_d = cnt_q + 8'd1;
        // Completion is checked before abort so a coincident op_done still captures.
        if (op_done) begin
          res_l_d = result[31:0];
          res_h_d = result[63:32];
          done_d  = 1'b1;
          state_d = CLEAR;
          start_d = 1'b0;
          clear_d = 1'b1;
        end else if (wr_ctrl && s_din[1]) begin
          state_d = CLEAR;
          start_d = 1'b0;
          clear_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = CLEAR;
          start_d = 1'b0;
          clear_d = 1'b1;
        end
      end
      CLEAR: begin
        state_d = IDLE;
        clear_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        start_d = 1'b0;
        clear_d = 1'b0;
      end
    endcase

    irq_d = inten_d & (done_d | err_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_l_q <= '0;
      res_h_q <= '0;
      inten_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      clear_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_l_q <= res_l_d;
      res_h_q <= res_h_d;
      inten_q <= inten_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      clear_q <= clear_d;
      irq_q   <= irq_d;
    end
  end

  always_comb begin
    s_dout = 32'd0;
    if (s_sel && !s_wr) begin
      case (s_addr)
        A_OPA:    s_dout = opa_q;
        A_OPB:    s_dout = opb_q;
        A_INTEN:  s_dout = {31'd0, inten_q};
        A_STATUS: s_dout = {28'd0, ovr_q, err_q, done_q, busy};
        A_RES_L:  s_dout = res_l_q;
        A_RES_H:  s_dout = res_h_q;
        default:  s_dout = 32'd0;
      endcase
    end
  end

  assign op_start     = start_q;
  assign op_clear     = clear_q;
  assign m_interrupt  = irq_q;
  assign multiplicand = opa_q;
  assign multiplier   = opb_q;

endmodule

// File: tb/tb_mul_ctrl.sv
// Purpose: testbench for mul_ctrl, with a stub multiplier of programmable latency and a
//          read scoreboard fed from a transaction-level model of the register file.
// Latency: inputs are driven 1 ns after posedge; read data is checked on the negedge.
// Backpressure: not applicable.
module tb_mul_ctrl;

  localparam int TIMEOUT = 127;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        s_sel, s_wr;
  logic [2:0]  s_addr;
  logic [31:0] s_din, s_dout;
  logic        m_interrupt, op_start, op_clear;
  logic [31:0] multiplicand, multiplier;
  logic        op_done;
  logic [63:0] result;

  always #5 clk = ~clk;

  mul_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_sel(s_sel), .s_wr(s_wr), .s_addr(s_addr), .s_din(s_din), .s_dout(s_dout),
    .m_interrupt(m_interrupt), .op_start(op_start), .op_clear(op_clear),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .op_done(op_done), .result(result)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    longint x, y;
    x = longint'($signed(a));
    y = longint'($signed(b));
    return 64'(x * y);
  endfunction

  // Stub multiplier: fires op_done once, stub_lat cycles after op_start rises.
  int   stub_lat  = 4;
  logic stub_dead = 1'b0;
  int   stub_cnt;
  logic stub_fired;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_done    <= 1'b0;
      result     <= '0;
      stub_cnt   <= 0;
      stub_fired <= 1'b0;
    end else if (!op_start) begin
      op_done    <= 1'b0;
      stub_cnt   <= 0;
      stub_fired <= 1'b0;
    end else if (stub_fired) begin
      op_done <= 1'b0;
    end else if (!stub_dead) begin
      if (stub_cnt >= stub_lat - 1) begin
        op_done    <= 1'b1;
        result     <= smul(multiplicand, multiplier);
        stub_fired <= 1'b1;
      end else begin
        stub_cnt <= stub_cnt + 1;
      end
    end
  end

  // Reference model of the programmer-visible state.
  logic [31:0] m_opa, m_opb, m_resl, m_resh;
  logic        m_inten, m_done, m_err, m_ovr;

  task automatic model_reset();
    m_opa = 0; m_opb = 0; m_resl = 0; m_resh = 0;
    m_inten = 0; m_done = 0; m_err = 0; m_ovr = 0;
  endtask

  function automatic logic [31:0] exp_status(input logic busy);
    return {28'd0, m_ovr, m_err, m_done, busy};
  endfunction

  function automatic logic exp_irq();
    return m_inten & (m_done | m_err);
  endfunction

  // Read scoreboard: expected data pushed at issue, popped by the monitor.
  typedef struct { logic [2:0] a; logic [31:0] e; } rd_t;
  rd_t sbq[$];

  always @(negedge clk) begin
    if (s_sel && !s_wr) begin
      if (sbq.size() == 0) begin
        n_checks++;
        $display("FAIL sb_underflow: read of addr %0d with no expectation", s_addr);
      end else begin
        rd_t r;
        r = sbq.pop_front();
        check($sformatf("rd_addr%0d", r.a), {32'd0, s_dout}, {32'd0, r.e});
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    s_sel = 1; s_wr = 1; s_addr = a; s_din = d;
    @(negedge clk);
    check("dout_on_write", {32'd0, s_dout}, 64'd0);
    tick();
    s_sel = 0; s_wr = 0;
  endtask

  task automatic bus_rd(input logic [2:0] a, input logic [31:0] e);
    rd_t r;
    r.a = a; r.e = e;
    sbq.push_back(r);
    s_sel = 1; s_wr = 0; s_addr = a;
    tick();
    s_sel = 0;
  endtask

  task automatic check_all_regs();
    bus_rd(3'd0, m_opa);
    bus_rd(3'd1, m_opb);
    bus_rd(3'd2, 32'd0);
    bus_rd(3'd3, {31'd0, m_inten});
    bus_rd(3'd4, exp_status(1'b0));
    bus_rd(3'd5, m_resl);
    bus_rd(3'd6, m_resh);
    bus_rd(3'd7, 32'd0);
  endtask

  task automatic set_ops(input logic [31:0] a, input logic [31:0] b);
    bus_wr(3'd0, a); m_opa = a;
    bus_wr(3'd1, b); m_opb = b;
  endtask

  task automatic set_inten(input logic v);
    bus_wr(3'd3, {31'd0, v}); m_inten = v;
  endtask

  task automatic clr_status(input logic [3:0] bits);
    bus_wr(3'd4, {28'd0, bits});
    if (bits[1]) m_done = 0;
    if (bits[2]) m_err  = 0;
    if (bits[3]) m_ovr  = 0;
    check("irq_after_status_write", m_interrupt, exp_irq());
  endtask

  // kind: 0 normal, 1 abort at EXEC cycle abort_at, 2 timeout, 3 busy writes (ovr),
  //       4 status clear landing on the capture cycle.
  task automatic run_op(input int kind, input int lat, input int abort_at);
    int n, hi, lows, early_irq;
    logic prev_done;
    stub_lat  = lat;
    stub_dead = (kind == 2);
    bus_wr(3'd2, 32'd1);
    m_done = 0; m_err = 0;
    check("start_latency", op_start, 1'b1);
    if (kind == 0 || kind == 3) bus_rd(3'd4, exp_status(1'b1));
    if (kind == 1) begin
      repeat (abort_at - 1) tick();
      bus_wr(3'd2, 32'd2);
    end
    if (kind == 3) begin
      bus_wr(3'd0, ~m_opa);
      bus_wr(3'd1, $urandom);
      bus_wr(3'd2, 32'd1);
      m_ovr = 1;
    end
    if (kind == 4) begin
      repeat (lat - 1) tick();
      bus_wr(3'd4, 32'hE);
      m_ovr = 0;
    end
    n = 0; hi = 0; lows = 0; early_irq = 0; prev_done = 0;
    while (!op_clear && n < 400) begin
      if (op_start) hi++; else lows++;
      if (m_interrupt) early_irq++;
      prev_done = op_done;
      tick();
      n++;
    end
    check("clear_seen", op_clear, 1'b1);
    check("start_held_in_exec", 64'(lows), 64'd0);
    check("no_irq_during_exec", 64'(early_irq), 64'd0);
    if (kind == 0 || kind == 3 || kind == 4) begin
      m_done = 1;
      {m_resh, m_resl} = smul(m_opa, m_opb);
    end
    if (kind == 2) begin
      m_err = 1;
      check("timeout_exec_cycles", 64'(hi), 64'(TIMEOUT));
    end
    if (kind == 0 || kind == 3) check("clear_follows_done", prev_done, 1'b1);
    check("start_low_in_clear", op_start, 1'b0);
    check("irq_at_clear", m_interrupt, exp_irq());
    tick();
    check("clear_one_cycle", op_clear, 1'b0);
  endtask

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int kind;
    reset_n = 0; s_sel = 0; s_wr = 0; s_addr = 0; s_din = 0;
    model_reset();
    #20;
    check("rst_op_start", op_start, 1'b0);
    check("rst_op_clear", op_clear, 1'b0);
    check("rst_irq", m_interrupt, 1'b0);
    #8 reset_n = 1;
    tick();
    check_all_regs();

    // Test 1: 7 * -7
    set_ops(32'd7, 32'hFFFF_FFF9);
    run_op(0, 5, 0);
    bus_rd(3'd5, 32'hFFFF_FFCF);
    bus_rd(3'd6, 32'hFFFF_FFFF);
    bus_rd(3'd4, 32'h2);

    // Test 2: interrupt and most-negative squared
    set_inten(1'b1);
    set_ops(32'h8000_0000, 32'h8000_0000);
    run_op(0, 7, 0);
    bus_rd(3'd5, 32'h0);
    bus_rd(3'd6, 32'h4000_0000);
    clr_status(4'h2);
    bus_rd(3'd4, exp_status(1'b0));

    // Test 3: writes while busy
    set_ops(32'd12345, 32'hFFFF_0003);
    run_op(3, 12, 0);
    check_all_regs();

    // Test 4: abort at EXEC cycle 3
    run_op(1, 60, 3);
    check_all_regs();

    // Test 5: dead multiplier, timeout
    set_inten(1'b1);
    run_op(2, 1, 0);
    check_all_regs();

    // Clear and start together: clear only
    bus_wr(3'd2, 32'd3);
    check("both_bits_clear_pulse", op_clear, 1'b1);
    check("both_bits_no_start", op_start, 1'b0);
    tick();
    check("both_bits_clear_done", op_clear, 1'b0);
    check_all_regs();

    // Status clear coinciding with capture: done survives
    set_ops(pick_op(), pick_op());
    run_op(4, 6, 0);
    check_all_regs();

    // Randomized operations
    for (int i = 0; i < 30; i++) begin
      set_ops(pick_op(), pick_op());
      if ($urandom_range(0, 3) == 0) set_inten($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 9))
        0, 1:    kind = 1;
        2, 3:    kind = 3;
        4:       kind = 4;
        5:       kind = (i % 10 == 5) ? 2 : 0;
        default: kind = 0;
      endcase
      case (kind)
        1:       run_op(1, 60, $urandom_range(1, 20));
        3:       run_op(3, $urandom_range(8, 30), 0);
        4:       run_op(4, $urandom_range(2, 20), 0);
        default: run_op(kind, $urandom_range(1, 30), 0);
      endcase
      check_all_regs();
      if ($urandom_range(0, 1) == 1) clr_status(4'($urandom_range(0, 15)));
    end

    // Test 6: asynchronous reset mid-EXEC
    set_inten(1'b1);
    set_ops(32'hDEAD_BEEF, 32'h1234_5678);
    stub_lat = 60; stub_dead = 0;
    bus_wr(3'd2, 32'd1);
    bus_wr(3'd0, 32'd5);
    tick();
    check("pre_reset_busy", op_start, 1'b1);
    reset_n = 0;
    #1;
    check("async_rst_op_start", op_start, 1'b0);
    check("async_rst_op_clear", op_clear, 1'b0);
    check("async_rst_irq", m_interrupt, 1'b0);
    model_reset();
    bus_rd(3'd0, 32'd0);
    bus_rd(3'd1, 32'd0);
    bus_rd(3'd4, 32'd0);
    bus_rd(3'd3, 32'd0);
    reset_n = 1;
    tick();
    check_all_regs();

    repeat (3) tick();
    check("sb_drained", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mul_ctrl.md
Name: mul_ctrl

Overview:
- Bus-slave front end for the 32x32 signed multiplier `mul`.
- Upstream side: holds the operands written over a simple single-cycle register bus.
- Sequences the multiplier's op_start/op_clear handshake.
- Downstream side: captures the 64-bit product on op_done, exposes it as two readable words, and raises a level interrupt.

Parameters:
- TIMEOUT, 127, max cycles in EXEC waiting for op_done before abort; 8-bit counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- s_sel  input  1  bus select for this slave.
- s_wr  input  1  1 = write, 0 = read (valid while s_sel).
- s_addr  input  3  word register index.
- s_din  input  32  write data.
- s_dout  output  32  read data, combinational; 0 when !s_sel or s_wr.
- m_interrupt  output  1  level interrupt.
- op_start  output  1  to mul; held high for the whole operation.
- op_clear  output  1  to mul; one-cycle pulse.
- multiplicand  output  32  to mul; equals the OPA register.
- multiplier  output  32  to mul; equals the OPB register.
- op_done  input  1  from mul.
- result  input  64  from mul; valid while op_done.

Behaviour:
- Register map (s_addr):
  - 0 OPA, RW.
  - 1 OPB, RW.
  - 2 CTRL, W only, reads 0: bit0 start, bit1 clear.
  - 3 INTEN, RW bit0.
  - 4 STATUS, read: bit0 busy, bit1 done, bit2 err, bit3 ovr; write 1 to bit1/2/3 clears that bit.
  - 5 RES_L, RO.
  - 6 RES_H, RO.
  - 7 reads 0, writes ignored.
- Reset: FSM=IDLE. OPA, OPB, RES_L, RES_H, INTEN, done, err, ovr, timeout counter all 0. op_start=0, op_clear=0, m_interrupt=0.
- The asynchronous reset aborts any operation immediately. The mul block shares reset_n.
- FSM states: IDLE, EXEC, CLEAR.
- IDLE:
  - Write CTRL bit0=1 -> EXEC next cycle. Also clears done and err, and zeroes the counter.
  - Write CTRL bit1=1 in IDLE -> CLEAR. This only pulses op_clear; RES_L/RES_H are kept.
  - If bit0 and bit1 are both set in one write, clear wins.
- EXEC:
  - op_start=1, busy=1, counter increments each cycle.
  - op_done=1 -> RES_L<=result[31:0], RES_H<=result[63:32], done<=1, go to CLEAR.
  - Counter reaches TIMEOUT without op_done -> err<=1, no capture, go to CLEAR.
  - Write CTRL bit1=1 -> abort: no capture, done stays 0, go to CLEAR.
  - If op_done and an abort write land in the same cycle, the capture wins and done is set.
  - Writes to OPA/OPB/CTRL.start while busy are ignored and set ovr<=1.
- CLEAR:
  - op_start=0, op_clear=1 for exactly one cycle, busy=1; then IDLE.
  - A new start write is accepted from IDLE only, so the earliest restart is on the cycle after CLEAR.
- Latency: start write at cycle N gives op_start high from N+1. When op_done first rises at cycle M, done and RES are visible from M+1, and op_clear pulses at M+1.
- m_interrupt = INTEN & (done | err), registered with the status bits. Clearing via STATUS write deasserts it on the next cycle.
- Status-clear writes and a same-cycle set: the set wins.
- The product is signed two's complement and is passed through unmodified; the controller does no arithmetic.

Test Plan:
1. Reset 28 ns, write OPA=7 and OPB=32'hFFFF_FFF9, then CTRL=1. Required:
   - op_start high until op_done.
   - RES_L=32'hFFFF_FFCF and RES_H=32'hFFFF_FFFF (-49).
   - STATUS=0x2 and one op_clear pulse.
2. INTEN=1, OPA=32'h8000_0000, OPB=32'h8000_0000, start. Required: m_interrupt rises one cycle after op_done; result 64'h4000_0000_0000_0000. Then write STATUS=0x2 -> done=0 and m_interrupt=0 on the next cycle.
3. While busy, write OPA=5 and CTRL=1. Required: OPA unchanged, ovr=1, the operation completes normally with the original product.
4. Start, then write CTRL=2 at EXEC cycle 3. Required: op_clear one-cycle pulse, done=0, RES unchanged from the previous op, back to IDLE.
5. Tie op_done=0 (stub mul). Required: after TIMEOUT=127 EXEC cycles, err=1, op_clear pulse, IDLE; with INTEN=1, m_interrupt=1.
6. Assert reset_n=0 mid-EXEC. Required: op_start, op_clear, and all status bits 0 asynchronously, with no wait for a clock edge; OPA/OPB read 0.
